// File: rtl/uart_link_pkg.sv
// Shared constants and FSM state types for the CPU-side UART byte link.

package uart_link_pkg;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    // STATUS register bit positions
    localparam int unsigned ST_RX_NEMPTY = 0;
    localparam int unsigned ST_TX_FULL   = 1;
    localparam int unsigned ST_TX_EMPTY  = 2;
    localparam int unsigned ST_RX_FULL   = 3;
    localparam int unsigned ST_TX_BUSY   = 4;
    localparam int unsigned ST_TXDROP    = 5;
    localparam int unsigned ST_RXOVF     = 6;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SENT,
        TX_DRAIN
    } tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; a push on full is accepted when
// the same cycle also pops.

module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/uart_link_bridge.sv
// CPU-side end of the UART byte link: bus-facing TX/RX FIFOs, STATUS register and
// the two handshake FSMs towards the serclk-domain UART core.

module uart_link_bridge
    import uart_link_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_hwclk,
    input  logic       i_reset,
    input  logic       i_addr,
    input  logic       i_wen,
    input  logic       i_ren,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic [7:0] o_txdata,
    output logic       o_txclk,
    input  logic       i_txready,
    input  logic [7:0] i_rxdata,
    input  logic       i_rxready,
    output logic       o_rxclk
);

    logic [SYNC_STAGES-1:0] r_txr_sync;
    logic [SYNC_STAGES-1:0] r_rxr_sync;
    logic                   w_txr_s;
    logic                   w_rxr_s;

    logic      w_wr_data;
    logic      w_wr_status;
    logic      w_rd_data;
    logic      w_rd_status;

    logic [7:0] w_tx_head;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_tx_pop;
    logic [7:0] w_rx_head;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_rx_push;

    tx_state_t  r_tx_state;
    tx_state_t  w_tx_state_nxt;
    logic       w_tx_launch;
    logic [7:0] r_txdata;
    logic       r_txclk;

    rx_state_t  r_rx_state;
    rx_state_t  w_rx_state_nxt;
    logic       w_rx_can_take;
    logic       w_rx_stall;
    logic       w_rx_ack_done;
    logic       r_rx_stalled;
    logic       r_rxclk;

    logic       r_txdrop;
    logic       r_rxovf;
    logic       w_txdrop_set;
    logic       w_rxovf_set;
    logic [7:0] w_status;
    logic [7:0] r_rdata;

    assign w_txr_s = r_txr_sync[SYNC_STAGES-1];
    assign w_rxr_s = r_rxr_sync[SYNC_STAGES-1];

    always_ff @(posedge i_hwclk) begin
        if (i_reset) begin
            r_txr_sync <= '0;
            r_rxr_sync <= '0;
        end else begin
            r_txr_sync <= {r_txr_sync[SYNC_STAGES-2:0], i_txready};
            r_rxr_sync <= {r_rxr_sync[SYNC_STAGES-2:0], i_rxready};
        end
    end

    assign w_wr_data   = i_wen & (i_addr == ADDR_DATA);
    assign w_wr_status = i_wen & (i_addr == ADDR_STATUS);
    assign w_rd_data   = i_ren & (i_addr == ADDR_DATA);
    assign w_rd_status = i_ren & (i_addr == ADDR_STATUS);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_hwclk),
        .i_reset (i_reset),
        .i_push  (w_wr_data),
        .i_pop   (w_tx_pop),
        .i_din   (i_wdata),
        .o_dout  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_hwclk),
        .i_reset (i_reset),
        .i_push  (w_rx_push),
        .i_pop   (w_rd_data),
        .i_din   (i_rxdata),
        .o_dout  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // TX FSM: the head byte stays in the FIFO until the UART drops txready.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_launch    = 1'b0;
        w_tx_pop       = 1'b0;
        unique case (r_tx_state)
            TX_IDLE: begin
                if (!w_tx_empty && w_txr_s) begin
                    w_tx_launch    = 1'b1;
                    w_tx_state_nxt = TX_SENT;
                end
            end
            TX_SENT: begin
                if (!w_txr_s) begin
                    w_tx_pop       = 1'b1;
                    w_tx_state_nxt = TX_DRAIN;
                end
            end
            TX_DRAIN: begin
                if (w_txr_s) begin
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_hwclk) begin
        if (i_reset) begin
            r_tx_state <= TX_IDLE;
            r_txdata   <= '0;
            r_txclk    <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            if (w_tx_launch) begin
                r_txdata <= w_tx_head;
                r_txclk  <= 1'b1;
            end else if (w_tx_pop) begin
                r_txclk  <= 1'b0;
            end
        end
    end

    // A bus pop in the same cycle frees a slot, so a full RX FIFO can still take the byte.
    assign w_rx_can_take = ~w_rx_full | w_rd_data;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_push      = 1'b0;
        w_rx_stall     = 1'b0;
        w_rx_ack_done  = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (w_rxr_s) begin
                    if (w_rx_can_take) begin
                        w_rx_push      = 1'b1;
                        w_rx_state_nxt = RX_ACK;
                    end else begin
                        w_rx_stall     = 1'b1;
                    end
                end
            end
            RX_ACK: begin
                if (!w_rxr_s) begin
                    w_rx_ack_done  = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_hwclk) begin
        if (i_reset) begin
            r_rx_state   <= RX_IDLE;
            r_rxclk      <= 1'b0;
            r_rx_stalled <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_rx_stalled <= w_rx_stall;
            if (w_rx_push) begin
                r_rxclk <= 1'b1;
            end else if (w_rx_ack_done) begin
                r_rxclk <= 1'b0;
            end
        end
    end

    // RXOVF fires only on the first cycle a given byte stalls.
    assign w_txdrop_set = w_wr_data & w_tx_full & ~w_tx_pop;
    assign w_rxovf_set  = w_rx_stall & ~r_rx_stalled;

    always_ff @(posedge i_hwclk) begin
        if (i_reset) begin
            r_txdrop <= 1'b0;
            r_rxovf  <= 1'b0;
        end else begin
            r_txdrop <= w_txdrop_set | (r_txdrop & ~w_wr_status);
            r_rxovf  <= w_rxovf_set | (r_rxovf & ~w_wr_status);
        end
    end

    always_comb begin
        w_status               = '0;
        w_status[ST_RX_NEMPTY] = ~w_rx_empty;
        w_status[ST_TX_FULL]   = w_tx_full;
        w_status[ST_TX_EMPTY]  = w_tx_empty;
        w_status[ST_RX_FULL]   = w_rx_full;
        w_status[ST_TX_BUSY]   = (r_tx_state != TX_IDLE);
        w_status[ST_TXDROP]    = r_txdrop;
        w_status[ST_RXOVF]     = r_rxovf;
    end

    always_ff @(posedge i_hwclk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if (w_rd_data) begin
            r_rdata <= w_rx_empty ? 8'h00 : w_rx_head;
        end else if (w_rd_status) begin
            r_rdata <= w_status;
        end
    end

    assign o_rdata  = r_rdata;
    assign o_txdata = r_txdata;
    assign o_txclk  = r_txclk;
    assign o_rxclk  = r_rxclk;

endmodule

// File: tb/tb_uart_link_bridge.sv
// Bench for uart_link_bridge: bus-side vector table plus a serclk-domain UART model
// feeding TX/RX scoreboards.

module tb_uart_link_bridge;
    import uart_link_pkg::*;

    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned SYNC_STAGES = 2;

    logic       hwclk  = 1'b0;
    logic       serclk = 1'b0;
    logic       reset;
    logic       addr;
    logic       wen;
    logic       ren;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] txdata;
    logic       txclk;
    logic       txready;
    logic [7:0] rxdata;
    logic       rxready;
    logic       rxclk;

    always #42 hwclk = ~hwclk;
    always #135 serclk = ~serclk;

    uart_link_bridge #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_hwclk   (hwclk),
        .i_reset   (reset),
        .i_addr    (addr),
        .i_wen     (wen),
        .i_ren     (ren),
        .i_wdata   (wdata),
        .o_rdata   (rdata),
        .o_txdata  (txdata),
        .o_txclk   (txclk),
        .i_txready (txready),
        .i_rxdata  (rxdata),
        .i_rxready (rxready),
        .o_rxclk   (rxclk)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_got[256];
    int         tx_got_n    = 0;
    int         tx_rd_idx   = 0;
    bit         tx_hold     = 1'b0;
    bit         tx_ignore   = 1'b0;
    logic [7:0] rx_req_data = 8'h00;
    int         rx_req_n    = 0;
    int         rx_served_n = 0;
    bit         rx_to       = 1'b0;

    // UART TX side: arms on a txclk rise while idle, then stays busy for a few serclks.
    initial begin : uart_tx_model
        int   busy;
        logic prev;
        busy    = 0;
        prev    = 1'b0;
        txready = 1'b1;
        forever begin
            @(posedge serclk);
            if (busy > 0) busy--;
            if (txready && !tx_ignore && txclk && !prev) begin
                tx_got[tx_got_n] = txdata;
                tx_got_n++;
                busy = 4;
            end
            prev    = txclk;
            txready = (busy == 0) && !tx_hold;
        end
    end

    // UART RX side: presents one requested byte, waits for the rxclk handshake.
    initial begin : uart_rx_model
        int served;
        int n;
        served  = 0;
        rxready = 1'b0;
        rxdata  = 8'h00;
        forever begin
            @(posedge serclk);
            if (rx_req_n != served) begin
                rxdata = rx_req_data;
                @(posedge serclk);
                rxready = 1'b1;
                n = 0;
                while (!rxclk && n < 4000) begin
                    @(posedge serclk);
                    n++;
                end
                if (!rxclk) rx_to = 1'b1;
                rxready = 1'b0;
                n = 0;
                while (rxclk && n < 4000) begin
                    @(posedge serclk);
                    n++;
                end
                if (rxclk) rx_to = 1'b1;
                served++;
                rx_served_n = served;
            end
        end
    end

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        @(negedge hwclk);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        @(negedge hwclk);
        wen   = 1'b0;
    endtask

    task automatic bus_read(input logic a, output logic [7:0] d);
        @(negedge hwclk);
        addr = a;
        ren  = 1'b1;
        @(negedge hwclk);
        ren  = 1'b0;
        d    = rdata;
    endtask

    task automatic tx_drain(input string name);
        int         n;
        logic [7:0] s;
        n = 0;
        while (tx_got_n < tx_rd_idx + tx_exp.size() && n < 6000) begin
            @(posedge hwclk);
            n++;
        end
        if (tx_got_n < tx_rd_idx + tx_exp.size()) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d bytes expected %0d", name,
                     tx_got_n - tx_rd_idx, tx_exp.size());
        end
        while (tx_rd_idx < tx_got_n) begin
            if (tx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected byte: got %0h expected none", name,
                         tx_got[tx_rd_idx]);
            end else begin
                check(name, 32'(tx_got[tx_rd_idx]), 32'(tx_exp.pop_front()));
            end
            tx_rd_idx++;
        end
        for (int i = 0; i < 100; i++) begin
            bus_read(ADDR_STATUS, s);
            if (!s[ST_TX_BUSY] && s[ST_TX_EMPTY]) break;
        end
    endtask

    task automatic rx_send(input logic [7:0] d);
        rx_req_data = d;
        rx_exp.push_back(d);
        rx_req_n++;
    endtask

    task automatic rx_wait_served(input int n, input string name);
        int k;
        k = 0;
        while (rx_served_n < n && k < 3000) begin
            @(posedge hwclk);
            k++;
        end
        if (rx_served_n < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d served expected %0d", name, rx_served_n, n);
        end
    endtask

    task automatic wait_rxready(input string name);
        int k;
        k = 0;
        while (!rxready && k < 100) begin
            @(posedge hwclk);
            k++;
        end
        if (!rxready) begin
            checks++;
            errors++;
            $display("FAIL %s: got rxready 0 expected 1", name);
        end
    endtask

    task automatic rx_pop_check(input string name);
        logic [7:0] v;
        bus_read(ADDR_DATA, v);
        if (rx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected nothing queued", name, v);
        end else begin
            check(name, 32'(v), 32'(rx_exp.pop_front()));
        end
    endtask

    typedef struct {
        logic       wr;
        logic       a;
        logic [7:0] d;
        logic       keep;
        logic [7:0] exp;
        string      name;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic a, input logic [7:0] d,
                                input logic keep, input logic [7:0] exp, input string name);
        vec_t v;
        v.wr   = wr;
        v.a    = a;
        v.d    = d;
        v.keep = keep;
        v.exp  = exp;
        v.name = name;
        return v;
    endfunction

    vec_t vecs[17];

    task automatic apply_vecs(input int lo, input int hi);
        logic [7:0] v;
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].a, vecs[i].d);
                if (vecs[i].a == ADDR_DATA && vecs[i].keep) tx_exp.push_back(vecs[i].d);
            end else begin
                bus_read(vecs[i].a, v);
                check(vecs[i].name, 32'(v), 32'(vecs[i].exp));
            end
        end
    endtask

    initial begin : main
        logic [7:0] v;
        int         lat;
        logic       rose;
        int         k;

        vecs[0] = mk(1'b1, ADDR_DATA, 8'h41, 1'b1, 8'h00, "t1_w41");
        vecs[1] = mk(1'b1, ADDR_DATA, 8'h42, 1'b1, 8'h00, "t1_w42");
        vecs[2] = mk(1'b1, ADDR_DATA, 8'h43, 1'b1, 8'h00, "t1_w43");
        for (int i = 0; i < 8; i++) begin
            vecs[3 + i] = mk(1'b1, ADDR_DATA, 8'(8'h10 + i), 1'b1, 8'h00, "t2_fill");
        end
        vecs[11] = mk(1'b0, ADDR_STATUS, 8'h00, 1'b0, 8'h02, "t2_status_full");
        vecs[12] = mk(1'b1, ADDR_DATA,   8'h18, 1'b0, 8'h00, "t2_w_drop");
        vecs[13] = mk(1'b0, ADDR_STATUS, 8'h00, 1'b0, 8'h22, "t2_status_drop");
        vecs[14] = mk(1'b1, ADDR_STATUS, 8'hff, 1'b0, 8'h00, "t2_clear");
        vecs[15] = mk(1'b0, ADDR_STATUS, 8'h00, 1'b0, 8'h02, "t2_status_cleared");
        vecs[16] = mk(1'b0, ADDR_DATA,   8'h00, 1'b0, 8'h00, "t2_rx_empty_read");

        reset = 1'b1;
        addr  = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = 8'h00;
        repeat (4) @(negedge hwclk);
        check("rst_txclk", 32'(txclk), 32'(0));
        check("rst_rxclk", 32'(rxclk), 32'(0));
        check("rst_txdata", 32'(txdata), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        reset = 1'b0;
        repeat (6) @(negedge hwclk);
        bus_read(ADDR_STATUS, v);
        check("rst_status", 32'(v), 32'(8'h04));

        // 1: three bytes out in order
        apply_vecs(0, 2);
        tx_drain("t1_tx");
        bus_read(ADDR_STATUS, v);
        check("t1_status", 32'(v), 32'(8'h04));

        // 2: overflow the TX FIFO while the UART is held busy
        tx_hold = 1'b1;
        repeat (10) @(negedge hwclk);
        apply_vecs(3, 16);
        tx_hold = 1'b0;
        tx_drain("t2_tx");

        // 3: single received byte and rxclk latency
        rx_send(8'h5a);
        wait_rxready("t3_rxready");
        lat = 1;
        while (!rxclk && lat < 20) begin
            @(posedge hwclk);
            #1;
            lat++;
        end
        check("t3_rxclk_latency", 32'(lat <= int'(SYNC_STAGES) + 2), 32'(1));
        rx_wait_served(1, "t3_served");
        bus_read(ADDR_STATUS, v);
        check("t3_status", 32'(v), 32'(8'h05));
        rx_pop_check("t3_data");
        bus_read(ADDR_DATA, v);
        check("t3_empty_read", 32'(v), 32'(8'h00));

        // 4 + 6: fill RX, stall a ninth byte, then pop while it is pushed
        for (int i = 0; i < 8; i++) begin
            rx_send(8'(8'h80 + i));
            rx_wait_served(2 + i, "t4_fill");
        end
        bus_read(ADDR_STATUS, v);
        check("t4_status_full", 32'(v), 32'(8'h0d));
        rx_send(8'h9c);
        wait_rxready("t4_rxready");
        rose = 1'b0;
        repeat (12) begin
            @(posedge hwclk);
            #1;
            if (rxclk) rose = 1'b1;
        end
        check("t4_no_ack", 32'(rose), 32'(0));
        bus_read(ADDR_STATUS, v);
        check("t4_status_ovf", 32'(v), 32'(8'h4d));
        bus_write(ADDR_STATUS, 8'h00);
        bus_read(ADDR_STATUS, v);
        check("t6_ovf_once", 32'(v), 32'(8'h0d));
        rx_pop_check("t6_pop_with_push");
        rx_wait_served(10, "t6_served");
        bus_read(ADDR_STATUS, v);
        check("t6_status_kept", 32'(v), 32'(8'h0d));
        k = 0;
        while (rx_exp.size() > 0 && k < 12) begin
            rx_pop_check("t4_readback");
            k++;
        end
        check("t4_readback_count", 32'(k + 1), 32'(9));
        bus_read(ADDR_STATUS, v);
        check("t4_status_empty", 32'(v), 32'(8'h04));

        // 5: reset while the TX FSM is in SENT
        tx_ignore = 1'b1;
        bus_write(ADDR_DATA, 8'h99);
        k = 0;
        while (!txclk && k < 50) begin
            @(negedge hwclk);
            k++;
        end
        check("t5_txclk_high", 32'(txclk), 32'(1));
        check("t5_txdata", 32'(txdata), 32'(8'h99));
        bus_read(ADDR_STATUS, v);
        check("t5_status_sent", 32'(v), 32'(8'h10));
        @(negedge hwclk);
        reset = 1'b1;
        @(negedge hwclk);
        reset = 1'b0;
        check("t5_txclk", 32'(txclk), 32'(0));
        check("t5_rxclk", 32'(rxclk), 32'(0));
        check("t5_txdata_rst", 32'(txdata), 32'(0));
        check("t5_rdata", 32'(rdata), 32'(0));
        bus_read(ADDR_STATUS, v);
        check("t5_status", 32'(v), 32'(8'h04));
        tx_ignore = 1'b0;
        repeat (8) @(negedge hwclk);
        bus_write(ADDR_DATA, 8'h77);
        tx_exp.push_back(8'h77);
        tx_drain("t5_tx");

        repeat (40) @(negedge hwclk);
        check("tx_total", 32'(tx_got_n), 32'(12));
        check("rx_timeout", 32'(rx_to), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
